// File: rtl/car_controller.sv
`default_nettype none
// ============================================================================
// Module      : car_controller
// Description : Moore FSM that sequences datapath_car through the delay, draw,
//               hold, erase and step phases for one enemy car. Owns the
//               per-step movement timer (frame divider), the car hit-point
//               counter and the destroyed/escaped outcome.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CLKS_PER_FRAME : clk cycles per frame tick (>= 2)
//   MOVE_FRAMES    : frame ticks spent in HOLD per one-pixel step (>= 1)
//   HP_INIT        : hits needed to destroy the car (1..15)
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : level, launch car (seen in IDLE, DEAD, ESCAPED)
//   hit                  : 1-cycle pulse, car took one hit
//   initial_delay_done   : datapath, initial delay expired
//   draw_done/erase_done : datapath, sprite fully drawn / erased
//   game_over            : datapath, car reached end of path
//   wait_start .. enable_draw : one-hot datapath controls (per state)
//   plot                 : VGA write enable (draw_car | erase_car)
//   car_alive/escaped/killed : car status
//   hp                   : remaining hit points
// ============================================================================
module car_controller #(
    parameter int CLKS_PER_FRAME = 1666667,
    parameter int MOVE_FRAMES    = 2,
    parameter int HP_INIT        = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       hit,
    input  logic       initial_delay_done,
    input  logic       draw_done,
    input  logic       erase_done,
    input  logic       game_over,
    output logic       wait_start,
    output logic       delay,
    output logic       draw_car,
    output logic       draw_wait,
    output logic       erase_car,
    output logic       increment,
    output logic       destroyed_state,
    output logic       enable_draw,
    output logic       plot,
    output logic       car_alive,
    output logic       car_escaped,
    output logic       car_killed,
    output logic [3:0] hp
);

    localparam int c_frame_w = $clog2(CLKS_PER_FRAME);
    localparam int c_step_w  = $clog2(MOVE_FRAMES + 1);

    localparam logic [c_frame_w-1:0] c_frame_last = c_frame_w'(CLKS_PER_FRAME - 1);
    localparam logic [c_step_w-1:0]  c_step_last  = c_step_w'(MOVE_FRAMES - 1);
    localparam logic [3:0]           c_hp_init    = 4'(HP_INIT);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_DELAY      = 4'd1,
        S_DRAW       = 4'd2,
        S_HOLD       = 4'd3,
        S_ERASE      = 4'd4,
        S_STEP       = 4'd5,
        S_ERASE_DEAD = 4'd6,
        S_KILL       = 4'd7,
        S_DEAD       = 4'd8,
        S_ESCAPED    = 4'd9
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_frame_w-1:0]  r_frame;
    logic [c_step_w-1:0]   r_step;
    logic [3:0]            r_hp;
    logic                  r_hit_pend;
    logic                  w_frame_wrap;
    logic                  w_hold_expire;

    assign hp = r_hp;

    // Hold expires on the frame wrap that completes the last step frame.
    assign w_frame_wrap  = (r_frame == c_frame_last);
    assign w_hold_expire = w_frame_wrap && (r_step == c_step_last);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:       if (start)              w_state_next = S_DELAY;
            S_DELAY:      if (initial_delay_done) w_state_next = S_DRAW;
            S_DRAW:       if (draw_done)          w_state_next = S_HOLD;
            S_HOLD: begin
                // Expiry uses the hp value before any same-cycle decrement,
                // and destruction takes priority over escape.
                if (w_hold_expire) begin
                    if (r_hp == 4'd0)   w_state_next = S_ERASE_DEAD;
                    else if (game_over) w_state_next = S_ESCAPED;
                    else                w_state_next = S_ERASE;
                end
            end
            S_ERASE:      if (erase_done)         w_state_next = S_STEP;
            S_STEP:                               w_state_next = S_DRAW;
            S_ERASE_DEAD: if (erase_done)         w_state_next = S_KILL;
            S_KILL:                               w_state_next = S_DEAD;
            S_DEAD,
            S_ESCAPED:    if (start)              w_state_next = S_IDLE;
            default:                              w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they always equal
    // the decode of the state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_frame         <= '0;
            r_step          <= '0;
            r_hp            <= c_hp_init;
            r_hit_pend      <= 1'b0;
            wait_start      <= 1'b1;
            delay           <= 1'b0;
            draw_car        <= 1'b0;
            draw_wait       <= 1'b0;
            erase_car       <= 1'b0;
            increment       <= 1'b0;
            destroyed_state <= 1'b0;
            enable_draw     <= 1'b0;
            plot            <= 1'b0;
            car_alive       <= 1'b0;
            car_escaped     <= 1'b0;
            car_killed      <= 1'b0;
        end else begin
            r_state <= w_state_next;

            wait_start      <= (w_state_next == S_IDLE);
            delay           <= (w_state_next == S_DELAY);
            draw_car        <= (w_state_next == S_DRAW);
            draw_wait       <= (w_state_next == S_HOLD);
            erase_car       <= (w_state_next == S_ERASE) || (w_state_next == S_ERASE_DEAD);
            increment       <= (w_state_next == S_STEP);
            destroyed_state <= (w_state_next == S_KILL);
            enable_draw     <= (w_state_next == S_KILL);
            plot            <= (w_state_next == S_DRAW) || (w_state_next == S_ERASE) ||
                               (w_state_next == S_ERASE_DEAD);
            car_alive       <= (w_state_next == S_DELAY) || (w_state_next == S_DRAW) ||
                               (w_state_next == S_HOLD)  || (w_state_next == S_ERASE) ||
                               (w_state_next == S_STEP);
            car_escaped     <= (w_state_next == S_ESCAPED);
            car_killed      <= (w_state_next == S_DEAD);

            // Movement timer only runs in HOLD; DRAW re-arms it.
            if (r_state == S_HOLD) begin
                if (w_frame_wrap) begin
                    r_frame <= '0;
                    r_step  <= r_step + c_step_w'(1);
                end else begin
                    r_frame <= r_frame + c_frame_w'(1);
                end
            end else if (r_state == S_DRAW) begin
                r_frame <= '0;
                r_step  <= '0;
            end

            // Hits are latched while the car is in play and applied one per
            // HOLD cycle; a hit arriving while one is already pending stays
            // pending for the next HOLD cycle.
            case (r_state)
                S_IDLE: begin
                    r_hit_pend <= 1'b0;
                    if (start) r_hp <= c_hp_init;
                end
                S_DEAD, S_ESCAPED, S_KILL: begin
                    r_hit_pend <= 1'b0;
                end
                S_HOLD: begin
                    if (r_hit_pend || hit) begin
                        if (r_hp != 4'd0) r_hp <= r_hp - 4'd1;
                        r_hit_pend <= r_hit_pend & hit;
                    end
                end
                default: begin
                    if (hit) r_hit_pend <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_car_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_controller
// Description : Directed self-checking bench for car_controller with
//               CLKS_PER_FRAME=4, MOVE_FRAMES=2, HP_INIT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_controller;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start, hit, initial_delay_done, draw_done, erase_done, game_over;
    logic       wait_start, delay, draw_car, draw_wait, erase_car, increment;
    logic       destroyed_state, enable_draw, plot, car_alive, car_escaped, car_killed;
    logic [3:0] hp;

    int tests = 0;
    int fails = 0;

    // Output vector order:
    // wait_start delay draw_car draw_wait | erase_car increment destroyed enable_draw |
    // plot car_alive car_escaped car_killed
    localparam logic [11:0] E_IDLE    = 12'b1000_0000_0000;
    localparam logic [11:0] E_DELAY   = 12'b0100_0000_0100;
    localparam logic [11:0] E_DRAW    = 12'b0010_0000_1100;
    localparam logic [11:0] E_HOLD    = 12'b0001_0000_0100;
    localparam logic [11:0] E_ERASE   = 12'b0000_1000_1100;
    localparam logic [11:0] E_STEP    = 12'b0000_0100_0100;
    localparam logic [11:0] E_ERASED  = 12'b0000_1000_1000;
    localparam logic [11:0] E_KILL    = 12'b0000_0011_0000;
    localparam logic [11:0] E_DEAD    = 12'b0000_0000_0001;
    localparam logic [11:0] E_ESCAPED = 12'b0000_0000_0010;

    car_controller #(
        .CLKS_PER_FRAME(4),
        .MOVE_FRAMES   (2),
        .HP_INIT       (3)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .start             (start),
        .hit               (hit),
        .initial_delay_done(initial_delay_done),
        .draw_done         (draw_done),
        .erase_done        (erase_done),
        .game_over         (game_over),
        .wait_start        (wait_start),
        .delay             (delay),
        .draw_car          (draw_car),
        .draw_wait         (draw_wait),
        .erase_car         (erase_car),
        .increment         (increment),
        .destroyed_state   (destroyed_state),
        .enable_draw       (enable_draw),
        .plot              (plot),
        .car_alive         (car_alive),
        .car_escaped       (car_escaped),
        .car_killed        (car_killed),
        .hp                (hp)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] outs();
        return {wait_start, delay, draw_car, draw_wait, erase_car, increment,
                destroyed_state, enable_draw, plot, car_alive, car_escaped, car_killed};
    endfunction

    // Advance one clock; sampling happens 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 0; hit = 0; initial_delay_done = 0; draw_done = 0;
        erase_done = 0; game_over = 0;
        resetn = 0;
        cyc();
        resetn = 1;
    endtask

    // From IDLE: one cycle each of DELAY and DRAW, ending on the first HOLD cycle.
    task automatic launch();
        start = 1; cyc(); start = 0;
        initial_delay_done = 1; cyc(); initial_delay_done = 0;
        draw_done = 1; cyc(); draw_done = 0;
    endtask

    // From the ERASE state: ERASE -> STEP -> DRAW -> first HOLD cycle.
    task automatic next_step();
        erase_done = 1; cyc(); erase_done = 0;
        cyc();
        draw_done = 1; cyc(); draw_done = 0;
    endtask

    task automatic test_reset();
        start = 0; hit = 0; initial_delay_done = 0; draw_done = 0;
        erase_done = 0; game_over = 0;
        resetn = 0;
        repeat (2) cyc();
        tests++; if (outs() !== E_IDLE) begin fails++; $display("FAIL reset_outs: got %b exp %b", outs(), E_IDLE); end
        tests++; if (hp !== 4'd3) begin fails++; $display("FAIL reset_hp: got %0d exp 3", hp); end
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++; if (outs() !== E_IDLE) begin fails++; $display("FAIL idle_hold_%0d: got %b exp %b", i, outs(), E_IDLE); end
        end
        launch();
        hit = 1; cyc(); hit = 0;
        tests++; if (hp !== 4'd2 || outs() !== E_HOLD) begin fails++; $display("FAIL pre_reset_hold: hp %0d outs %b exp hp 2 outs %b", hp, outs(), E_HOLD); end
        #2 resetn = 0;
        #1;
        tests++; if (outs() !== E_IDLE || hp !== 4'd3) begin fails++; $display("FAIL async_reset: hp %0d outs %b exp hp 3 outs %b", hp, outs(), E_IDLE); end
        cyc();
        resetn = 1;
        cyc();
        tests++; if (outs() !== E_IDLE) begin fails++; $display("FAIL post_reset_idle: got %b exp %b", outs(), E_IDLE); end
    endtask

    task automatic test_launch_step();
        int cnt;
        do_reset();
        start = 1; cyc(); start = 0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (outs() !== E_DELAY) begin fails++; $display("FAIL t2_delay_%0d: got %b exp %b", i, outs(), E_DELAY); end
            cyc();
        end
        initial_delay_done = 1; cyc(); initial_delay_done = 0;
        for (int i = 0; i < 9; i++) begin
            tests++; if (outs() !== E_DRAW) begin fails++; $display("FAIL t2_draw_%0d: got %b exp %b", i, outs(), E_DRAW); end
            cyc();
        end
        draw_done = 1; cyc(); draw_done = 0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (outs() === E_HOLD) cnt++;
            else break;
            cyc();
        end
        tests++; if (cnt != 8) begin fails++; $display("FAIL t2_hold_len: got %0d exp 8", cnt); end
        tests++; if (outs() !== E_ERASE) begin fails++; $display("FAIL t2_erase: got %b exp %b", outs(), E_ERASE); end
        cyc();
        tests++; if (outs() !== E_ERASE) begin fails++; $display("FAIL t2_erase_wait: got %b exp %b", outs(), E_ERASE); end
        erase_done = 1; cyc(); erase_done = 0;
        tests++; if (outs() !== E_STEP) begin fails++; $display("FAIL t2_step: got %b exp %b", outs(), E_STEP); end
        cyc();
        tests++; if (outs() !== E_DRAW) begin fails++; $display("FAIL t2_redraw: got %b exp %b", outs(), E_DRAW); end
    endtask

    task automatic test_kill();
        do_reset();
        launch();
        for (int k = 0; k < 3; k++) begin
            hit = 1; cyc(); hit = 0;
            tests++; if (hp !== 4'(2 - k)) begin fails++; $display("FAIL t3_hp_%0d: got %0d exp %0d", k, hp, 2 - k); end
            repeat (7) cyc();
            if (k < 2) begin
                tests++; if (outs() !== E_ERASE) begin fails++; $display("FAIL t3_erase_%0d: got %b exp %b", k, outs(), E_ERASE); end
                next_step();
            end
        end
        tests++; if ((outs() | 12'b100) !== (E_ERASED | 12'b100)) begin fails++; $display("FAIL t3_erase_dead: got %b exp %b", outs(), E_ERASED); end
        hit = 1; cyc(); hit = 0;
        erase_done = 1; cyc(); erase_done = 0;
        tests++; if (outs() !== E_KILL) begin fails++; $display("FAIL t3_kill: got %b exp %b", outs(), E_KILL); end
        cyc();
        tests++; if (outs() !== E_DEAD || hp !== 4'd0) begin fails++; $display("FAIL t3_dead: outs %b hp %0d exp outs %b hp 0", outs(), hp, E_DEAD); end
        hit = 1; cyc(); hit = 0;
        cyc();
        tests++; if (outs() !== E_DEAD || hp !== 4'd0) begin fails++; $display("FAIL t3_dead_hold: outs %b hp %0d exp outs %b hp 0", outs(), hp, E_DEAD); end
    endtask

    task automatic test_back_to_back();
        // Continues from DEAD: start held gives one IDLE cycle then DELAY.
        start = 1; cyc();
        tests++; if (outs() !== E_IDLE) begin fails++; $display("FAIL b2b_idle: got %b exp %b", outs(), E_IDLE); end
        cyc();
        tests++; if (outs() !== E_DELAY || hp !== 4'd3) begin fails++; $display("FAIL b2b_delay: outs %b hp %0d exp outs %b hp 3", outs(), hp, E_DELAY); end
        start = 0;
    endtask

    task automatic test_escape();
        do_reset();
        launch();
        hit = 1; cyc(); hit = 0;
        game_over = 1;
        repeat (7) cyc();
        tests++; if (outs() !== E_ESCAPED || hp !== 4'd2) begin fails++; $display("FAIL t4_escaped: outs %b hp %0d exp outs %b hp 2", outs(), hp, E_ESCAPED); end
        game_over = 0;
        cyc();
        tests++; if (outs() !== E_ESCAPED) begin fails++; $display("FAIL t4_escaped_hold: got %b exp %b", outs(), E_ESCAPED); end
        start = 1; cyc();
        tests++; if (outs() !== E_IDLE) begin fails++; $display("FAIL t4_idle: got %b exp %b", outs(), E_IDLE); end
        cyc(); start = 0;
        tests++; if (outs() !== E_DELAY || hp !== 4'd3) begin fails++; $display("FAIL t4_relaunch: outs %b hp %0d exp outs %b hp 3", outs(), hp, E_DELAY); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        launch();
        hit = 1; cyc(); cyc(); hit = 0;
        tests++; if (hp !== 4'd1) begin fails++; $display("FAIL t5_hp1: got %0d exp 1", hp); end
        repeat (5) cyc();
        hit = 1; cyc(); hit = 0;
        tests++; if (outs() !== E_ERASE || hp !== 4'd0) begin fails++; $display("FAIL t5_erase: outs %b hp %0d exp outs %b hp 0", outs(), hp, E_ERASE); end
        next_step();
        game_over = 1;
        repeat (8) cyc();
        game_over = 0;
        tests++; if ((outs() | 12'b100) !== (E_ERASED | 12'b100)) begin fails++; $display("FAIL t5_kill_wins: got %b exp %b", outs(), E_ERASED); end
    endtask

    task automatic test_stray_hits();
        do_reset();
        hit = 1; cyc(); hit = 0;
        cyc();
        tests++; if (outs() !== E_IDLE || hp !== 4'd3) begin fails++; $display("FAIL t6_idle_hit: outs %b hp %0d exp outs %b hp 3", outs(), hp, E_IDLE); end
        start = 1; cyc(); start = 0;
        hit = 1; cyc(); hit = 0;
        tests++; if (outs() !== E_DELAY || hp !== 4'd3) begin fails++; $display("FAIL t6_delay_hit: outs %b hp %0d exp outs %b hp 3", outs(), hp, E_DELAY); end
        initial_delay_done = 1; cyc(); initial_delay_done = 0;
        draw_done = 1; cyc(); draw_done = 0;
        tests++; if (outs() !== E_HOLD || hp !== 4'd3) begin fails++; $display("FAIL t6_hold_entry: outs %b hp %0d exp outs %b hp 3", outs(), hp, E_HOLD); end
        cyc();
        tests++; if (hp !== 4'd2) begin fails++; $display("FAIL t6_pending_applied: got %0d exp 2", hp); end
    endtask

    initial begin
        test_reset();
        test_launch_step();
        test_kill();
        test_back_to_back();
        test_escape();
        test_simultaneous();
        test_stray_hits();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
